// File: rtl/reg_write_pkg.sv
// Shared constants and the writeback request type for the register-file write path.
package reg_write_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Two-push / one-pop ring buffer of writeback requests; exposes its contents in age order
// (index 0 = head) so the top can reduce over them without knowing the pointers.
module wb_fifo
  import reg_write_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push0,
  input  wb_req_t               i_req0,
  input  logic                  i_push1,
  input  wb_req_t               i_req1,
  input  logic                  i_pop,
  output wb_req_t [DEPTH-1:0]   o_entries,
  output logic    [DEPTH-1:0]   o_vld,
  output logic    [CNT_W-1:0]   o_count
);
  wb_req_t [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;

  logic [1:0]          w_npush;
  logic [PTR_W-1:0]    w_wp1;

  assign w_npush = {1'b0, i_push0} + {1'b0, i_push1};
  assign w_wp1   = r_wr_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push0) r_mem[r_wr_ptr] <= i_req0;
      // push1 lands behind push0 so mem stays older than alu
      if (i_push1) r_mem[i_push0 ? w_wp1 : r_wr_ptr] <= i_req1;
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_npush);
      if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count  <= r_count + CNT_W'(w_npush) - CNT_W'(i_pop);
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    logic [PTR_W-1:0] w_idx;
    assign w_idx        = r_rd_ptr + PTR_W'(k);
    assign o_entries[k] = r_mem[w_idx];
    assign o_vld[k]     = (CNT_W'(k) < r_count);
  end

  assign o_count = r_count;
endmodule

// File: rtl/reg_write_scheduler.sv
// Register-file write scheduler: merges mem/alu writebacks into one write port and
// publishes a pending scoreboard. Define REG_WRITE_FWD_EN to add two forwarding lookups.
module reg_write_scheduler
  import reg_write_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mem_valid,
  input  logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       mem_data,
  input  logic                    alu_valid,
  input  logic [ADDR_W-1:0]       alu_addr,
  input  logic [DATA_W-1:0]       alu_data,
  output logic                    in_ready,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       write_addr,
  output logic [DATA_W-1:0]       write_data,
  output logic [NUM_REGS-1:0]     pending,
`ifdef REG_WRITE_FWD_EN
  input  logic [ADDR_W-1:0]       fwd_addr1,
  input  logic [ADDR_W-1:0]       fwd_addr2,
  output logic                    fwd_hit1,
  output logic                    fwd_hit2,
  output logic [DATA_W-1:0]       fwd_data1,
  output logic [DATA_W-1:0]       fwd_data2,
`endif
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_req_t [DEPTH-1:0] w_ent;
  logic    [DEPTH-1:0] w_vld;
  logic    [CNT_W-1:0] w_count;
  logic                r_overflow;
  logic                w_in_ready;

  // Two free slots are required so a dual push can never be half-accepted.
  assign w_in_ready = (w_count <= CNT_W'(DEPTH - 2));

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push0   (mem_valid & w_in_ready),
    .i_req0    ('{addr: mem_addr, data: mem_data}),
    .i_push1   (alu_valid & w_in_ready),
    .i_req1    ('{addr: alu_addr, data: alu_data}),
    .i_pop     (w_vld[0]),
    .o_entries (w_ent),
    .o_vld     (w_vld),
    .o_count   (w_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_overflow <= 1'b0;
    else if (!w_in_ready && (mem_valid || alu_valid)) r_overflow <= 1'b1;
  end

  assign in_ready   = w_in_ready;
  assign wr_en      = w_vld[0];
  assign write_addr = w_vld[0] ? w_ent[0].addr : '0;
  assign write_data = w_vld[0] ? w_ent[0].data : '0;
  assign count      = w_count;
  assign overflow   = r_overflow;

  always_comb begin
    pending = '0;
    for (int k = 0; k < DEPTH; k++)
      if (w_vld[k]) pending[w_ent[k].addr] = 1'b1;
  end

`ifdef REG_WRITE_FWD_EN
  // Scan oldest to youngest; the last match is the youngest and wins.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_vld[k] && w_ent[k].addr == fwd_addr1) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = w_ent[k].data;
      end
      if (w_vld[k] && w_ent[k].addr == fwd_addr2) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = w_ent[k].data;
      end
    end
  end
`endif
endmodule

// File: tb/tb_reg_write_scheduler.sv
// Directed bench for reg_write_scheduler; forwarding checks run when REG_WRITE_FWD_EN is defined.
module tb_reg_write_scheduler;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, alu_valid;
  logic [3:0]  mem_addr, alu_addr;
  logic [31:0] mem_data, alu_data;
  logic        in_ready, wr_en, overflow;
  logic [3:0]  write_addr;
  logic [31:0] write_data;
  logic [15:0] pending;
  logic [2:0]  count;
`ifdef REG_WRITE_FWD_EN
  logic [3:0]  fwd_addr1 = 4'd0, fwd_addr2 = 4'd0;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rf [16];

  always #5 clk = ~clk;

  reg_write_scheduler #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .in_ready(in_ready), .wr_en(wr_en), .write_addr(write_addr),
    .write_data(write_data), .pending(pending),
`ifdef REG_WRITE_FWD_EN
    .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
`endif
    .count(count), .overflow(overflow)
  );

  // Register-file stand-in: commits the write port at each edge.
  always @(posedge clk)
    if (rst_n && wr_en) rf[write_addr] <= write_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mv, input logic [3:0] ma, input logic [31:0] md,
                       input logic av, input logic [3:0] aa, input logic [31:0] ad);
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = '0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_pending", pending, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_overflow", overflow, 0);
    chk("rst_wa", write_addr, 0);
    chk("rst_wd", write_data, 0);
    rst_n = 1'b1;
    tick();

    // single alu push
    drive(0, 0, 0, 1, 4'd3, 32'h0000_00AA);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("single_wr_en", wr_en, 1);
    chk("single_wa", write_addr, 3);
    chk("single_wd", write_data, 32'hAA);
    chk("single_pending", pending, 16'h0008);
    chk("single_count", count, 1);
    tick();
    chk("single_done_wr_en", wr_en, 0);
    chk("single_done_pending", pending, 0);
    chk("single_rf3", rf[3], 32'hAA);

    // dual push to the same register: alu must land last
    drive(1, 4'd5, 32'h1111_1111, 1, 4'd5, 32'h2222_2222);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("dual_count", count, 2);
    chk("dual_wd0", write_data, 32'h1111_1111);
    chk("dual_pending", pending, 16'h0020);
    tick();
    chk("dual_wd1", write_data, 32'h2222_2222);
    chk("dual_count1", count, 1);
    tick();
    chk("dual_wr_en_off", wr_en, 0);
    chk("dual_rf5", rf[5], 32'h2222_2222);

    // fill while draining, then a dropped dual push (pointers wrap here)
    drive(1, 4'd1, 32'hA1, 1, 4'd2, 32'hA2);
    tick();
    chk("fill_count0", count, 2);
    chk("fill_ready0", in_ready, 1);
    drive(1, 4'd3, 32'hA3, 1, 4'd4, 32'hA4);
    tick();
    chk("fill_count1", count, 3);
    chk("fill_ready1", in_ready, 0);
    chk("fill_head", write_addr, 2);
    chk("fill_ovf_before", overflow, 0);
    drive(1, 4'd5, 32'hA5, 1, 4'd6, 32'hA6);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("drop_count", count, 2);
    chk("drop_overflow", overflow, 1);
    chk("drop_pending", pending, 16'h0018);
    chk("drain_wd3", write_data, 32'hA3);
    tick();
    chk("drain_wd4", write_data, 32'hA4);
    chk("drain_wa4", write_addr, 4);
    tick();
    chk("drain_empty", wr_en, 0);
    chk("ovf_sticky", overflow, 1);
    chk("drain_rf2", rf[2], 32'hA2);

    // reset in the middle of traffic
    drive(1, 4'd7, 32'hB1, 1, 4'd8, 32'hB2);
    tick();
    drive(1, 4'd9, 32'hB3, 1, 4'd10, 32'hB4);
    tick();
    chk("mid_count", count, 3);
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    // PC register queued like any other
    drive(0, 0, 0, 1, 4'd15, 32'hF00D);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("pc_wa", write_addr, 15);
    chk("pc_pending", pending, 16'h8000);
    tick();

`ifdef REG_WRITE_FWD_EN
    drive(1, 4'd7, 32'h10, 1, 4'd7, 32'h20);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    fwd_addr1 = 4'd7;
    fwd_addr2 = 4'd8;
    #1;
    chk("fwd_hit1", fwd_hit1, 1);
    chk("fwd_data1", fwd_data1, 32'h20);
    chk("fwd_hit2", fwd_hit2, 0);
    chk("fwd_data2", fwd_data2, 0);
    tick();
    tick();
    chk("fwd_empty_hit1", fwd_hit1, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
